// File: rtl/clk_train_pattern_gen_pkg.sv
// clk_train_pkg: shared modes, FSM states and idle lane levels for the clock training generator
package clk_train_pkg;
  typedef enum logic [1:0] {MODE_NORMAL = 2'd0, MODE_FREERUN = 2'd1, MODE_TRACK = 2'd2} mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
  localparam logic IDLE_CKP = 1'b0;
  localparam logic IDLE_CKN = 1'b0;
  localparam logic IDLE_TRK = 1'b0;
endpackage

// File: rtl/clk_train_pattern_gen_if.sv
// clk_train_pattern_gen_if: control, handshake and lane words of the clock training generator
interface clk_train_pattern_gen_if #(parameter int SER_W = 32, parameter int ITER_W = 8);
  logic start;
  logic stop;
  logic [1:0] mode;
  logic [ITER_W-1:0] iterations;
  logic ready;
  logic valid;
  logic [SER_W-1:0] ckp_word;
  logic [SER_W-1:0] ckn_word;
  logic [SER_W-1:0] trk_word;
  logic busy;
  logic done;
  logic aborted;
  modport master(output start, stop, mode, iterations, ready,
                 input valid, ckp_word, ckn_word, trk_word, busy, done, aborted);
  modport slave(input start, stop, mode, iterations, ready,
                output valid, ckp_word, ckn_word, trk_word, busy, done, aborted);
endinterface

// File: rtl/clk_train_pattern_gen_word_gen.sv
// clk_train_word_gen: combinational per-UI CKP/CKN/TRACK word builder for one SER_W word
module clk_train_word_gen
  import clk_train_pkg::*;
#(
  parameter int SER_W = 32,
  parameter int ON_UI = 32,
  parameter int OFF_UI = 16,
  parameter int ITER_W = 8,
  parameter int POS_W = 7
) (
  input  logic [POS_W-1:0]  pos,
  input  logic [ITER_W:0]   iter,
  input  logic [ITER_W-1:0] count,
  input  mode_e             mode,
  output logic [SER_W-1:0]  ckp,
  output logic [SER_W-1:0]  ckn,
  output logic [SER_W-1:0]  trk
);
  localparam int P = ON_UI + OFF_UI;
  for (genvar k = 0; k < SER_W; k++) begin : g_bit
    logic [POS_W-1:0] g, p;
    logic [ITER_W:0] it;
    logic wrap, act, tog, ph;
    assign g = pos + POS_W'(k);
    assign wrap = g >= POS_W'(P);
    assign p = wrap ? g - POS_W'(P) : g;
    assign it = iter + (ITER_W+1)'(wrap);
    assign act = mode == MODE_FREERUN || it < {1'b0, count};
    assign tog = act && (mode == MODE_FREERUN || p < POS_W'(ON_UI));
    // free-run ignores the burst/idle framing, so phase comes straight from the UI index
    assign ph = mode == MODE_FREERUN ? g[0] : p[0];
    assign trk[k] = tog && !ph;
    assign ckp[k] = mode != MODE_TRACK && tog && !ph;
    assign ckn[k] = mode != MODE_TRACK && tog && ph;
  end
endmodule

// File: rtl/clk_train_pattern_gen.sv
// clk_train_pattern_gen: word-parallel forwarded-clock training pattern generator with
// programmable iterations, free-run/track modes, abort and valid/ready backpressure
module clk_train_pattern_gen
  import clk_train_pkg::*;
#(
  parameter int SER_W = 32,
  parameter int ON_UI = 32,
  parameter int OFF_UI = 16,
  parameter int ITER_W = 8
) (
  input logic i_dig_clk,
  input logic i_rst,
  clk_train_pattern_gen_if.slave bus
);
  localparam int P = ON_UI + OFF_UI;
  localparam int POS_W = $clog2(P + SER_W);
  state_e state, state_n;
  mode_e mode, mode_n, mode_in;
  logic [POS_W-1:0] pos, pos_n, pos_sum;
  logic [ITER_W:0] iter, iter_n;
  logic [ITER_W-1:0] cnt, cnt_n;
  logic valid, done, done_n, aborted, aborted_n, accept, wrap;
  logic [SER_W-1:0] ckp, ckn, trk, gen_ckp, gen_ckn, gen_trk;
  assign mode_in = bus.mode == 2'd1 ? MODE_FREERUN : bus.mode == 2'd2 ? MODE_TRACK : MODE_NORMAL;
  assign accept = valid && bus.ready;
  assign pos_sum = pos + POS_W'(SER_W);
  assign wrap = pos_sum >= POS_W'(P);
  always_comb begin
    state_n = state;
    mode_n = mode;
    cnt_n = cnt;
    pos_n = pos;
    iter_n = iter;
    done_n = done;
    aborted_n = aborted;
    if (state != ST_RUN && bus.start) begin
      mode_n = mode_in;
      cnt_n = bus.iterations;
      pos_n = '0;
      iter_n = '0;
      done_n = mode_in != MODE_FREERUN && bus.iterations == '0;
      aborted_n = 1'b0;
      state_n = done_n ? ST_DONE : ST_RUN;
    end else if (state == ST_RUN && bus.stop) begin
      state_n = ST_DONE;
      done_n = 1'b1;
      aborted_n = mode != MODE_FREERUN;
    end else if (state == ST_RUN && accept) begin
      pos_n = wrap ? pos_sum - POS_W'(P) : pos_sum;
      iter_n = iter + (ITER_W+1)'(wrap);
      // next word would start at or past count*P, so the accepted word was the last
      if (mode != MODE_FREERUN && iter_n >= {1'b0, cnt}) begin
        state_n = ST_DONE;
        done_n = 1'b1;
      end
    end
  end
  clk_train_word_gen #(.SER_W(SER_W), .ON_UI(ON_UI), .OFF_UI(OFF_UI), .ITER_W(ITER_W), .POS_W(POS_W)) u_gen (
    .pos(pos_n), .iter(iter_n), .count(cnt_n), .mode(mode_n),
    .ckp(gen_ckp), .ckn(gen_ckn), .trk(gen_trk)
  );
  always_ff @(posedge i_dig_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      mode <= MODE_NORMAL;
      cnt <= '0;
      pos <= '0;
      iter <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
      valid <= 1'b0;
      ckp <= '0;
      ckn <= '0;
      trk <= '0;
    end else begin
      state <= state_n;
      mode <= mode_n;
      cnt <= cnt_n;
      pos <= pos_n;
      iter <= iter_n;
      done <= done_n;
      aborted <= aborted_n;
      valid <= state_n == ST_RUN;
      ckp <= state_n == ST_RUN ? gen_ckp : {SER_W{IDLE_CKP}};
      ckn <= state_n == ST_RUN ? gen_ckn : {SER_W{IDLE_CKN}};
      trk <= state_n == ST_RUN ? gen_trk : {SER_W{IDLE_TRK}};
    end
  end
  assign bus.valid = valid;
  assign bus.ckp_word = ckp;
  assign bus.ckn_word = ckn;
  assign bus.trk_word = trk;
  assign bus.busy = state == ST_RUN;
  assign bus.done = done;
  assign bus.aborted = aborted;
endmodule
